// File: rtl/grid_painter.sv
// Board-grid painter: COLS x ROWS grid with cursor frame, 2-clock colour latency.
// Optional: define GRID_CHECKER_EN to dim every odd (col^row) cell interior to 3/4.
module grid_painter #(
    parameter int          H_ORIGIN = 40,
    parameter int          V_ORIGIN = 40,
    parameter int          CELL     = 40,
    parameter int          COLS     = 10,
    parameter int          ROWS     = 10,
    parameter int          LINE_W   = 1,
    parameter int          CURSOR_W = 3,
    parameter logic [23:0] CELL_RGB = 24'hFFFFFF,
    parameter logic [23:0] LINE_RGB = 24'h000000,
    parameter logic [23:0] BG_RGB   = 24'h000000,
    parameter logic [23:0] CUR_RGB  = 24'hFF0000,
    localparam int         CW       = $clog2(COLS + 1),
    localparam int         RW       = $clog2(ROWS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [9:0]    hdata,
    input  logic [9:0]    vdata,
    input  logic [CW-1:0] cursor_col,
    input  logic [RW-1:0] cursor_row,
    input  logic          cursor_vld,
    output logic [7:0]    video_red,
    output logic [7:0]    video_green,
    output logic [7:0]    video_blue,
    output logic [CW-1:0] cell_col,
    output logic [RW-1:0] cell_row,
    output logic          in_grid
);
    localparam int PW = $clog2(CELL);
    localparam logic [9:0]    H_O     = 10'(H_ORIGIN);
    localparam logic [9:0]    V_O     = 10'(V_ORIGIN);
    localparam logic [PW-1:0] PX_LAST = PW'(CELL - 1);
    localparam logic [PW-1:0] LW      = PW'(LINE_W);
    localparam logic [PW-1:0] CUR_LO  = PW'(CURSOR_W);
    localparam logic [PW-1:0] CUR_HI  = PW'(CELL - CURSOR_W);
    localparam logic [CW-1:0] COLS_C  = CW'(COLS);
    localparam logic [RW-1:0] ROWS_C  = RW'(ROWS);

`ifdef GRID_CHECKER_EN
    function automatic logic [7:0] dim8(input logic [7:0] c);
        return c - (c >> 2);
    endfunction
    localparam logic [23:0] CELL_DIM = {dim8(CELL_RGB[23:16]),
                                        dim8(CELL_RGB[15:8]),
                                        dim8(CELL_RGB[7:0])};
`endif

    logic [PW-1:0] hpx_q, hpx_d, vpx_q, vpx_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          hact_q, hact_d, vact_q, vact_d;
    logic [CW-1:0] sh_col_q;
    logic [RW-1:0] sh_row_q;
    logic          sh_vld_q;
    logic [23:0]   rgb_q, rgb_d;
    logic          cur_band, cur_hit;

    always_comb begin
        hpx_d  = hpx_q;
        col_d  = col_q;
        hact_d = hact_q;
        if (hdata == H_O) begin
            hpx_d  = '0;
            col_d  = '0;
            hact_d = 1'b1;
        end else if (hact_q) begin
            if (col_q == COLS_C) begin
                hact_d = 1'b0;
            end else if (hpx_q == PX_LAST) begin
                hpx_d = '0;
                col_d = col_q + 1'b1;
            end else begin
                hpx_d = hpx_q + 1'b1;
            end
        end
    end

    // Vertical counters only advance on the first pixel of each line
    always_comb begin
        vpx_d  = vpx_q;
        row_d  = row_q;
        vact_d = vact_q;
        if (hdata == '0) begin
            if (vdata == V_O) begin
                vpx_d  = '0;
                row_d  = '0;
                vact_d = 1'b1;
            end else if (vact_q) begin
                if (row_q == ROWS_C) begin
                    vact_d = 1'b0;
                end else if (vpx_q == PX_LAST) begin
                    vpx_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    vpx_d = vpx_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        cur_band = (hpx_q < CUR_LO) || (hpx_q >= CUR_HI) ||
                   (vpx_q < CUR_LO) || (vpx_q >= CUR_HI);
        cur_hit  = sh_vld_q && (col_q == sh_col_q) && (row_q == sh_row_q) &&
                   (col_q < COLS_C) && (row_q < ROWS_C) && cur_band;
        rgb_d    = CELL_RGB;
        if (!(hact_q && vact_q)) begin
            rgb_d = BG_RGB;
        end else if (cur_hit) begin
            rgb_d = CUR_RGB;
        end else if ((hpx_q < LW) || (vpx_q < LW)) begin
            rgb_d = LINE_RGB;
        end else begin
`ifdef GRID_CHECKER_EN
            if (col_q[0] ^ row_q[0]) rgb_d = CELL_DIM;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpx_q    <= '0;
            vpx_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            hact_q   <= 1'b0;
            vact_q   <= 1'b0;
            sh_col_q <= '0;
            sh_row_q <= '0;
            sh_vld_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            hpx_q  <= hpx_d;
            vpx_q  <= vpx_d;
            col_q  <= col_d;
            row_q  <= row_d;
            hact_q <= hact_d;
            vact_q <= vact_d;
            rgb_q  <= rgb_d;
            // Cursor is sampled once per frame so it never tears mid-scan
            if (hdata == '0 && vdata == '0) begin
                sh_col_q <= cursor_col;
                sh_row_q <= cursor_row;
                sh_vld_q <= cursor_vld;
            end
        end
    end

    assign video_red   = rgb_q[23:16];
    assign video_green = rgb_q[15:8];
    assign video_blue  = rgb_q[7:0];
    assign cell_col    = col_q;
    assign cell_row    = row_q;
    assign in_grid     = hact_q && vact_q;
endmodule

// File: tb/tb_grid_painter.sv
// Scoreboard bench for grid_painter: checkpoints queue expected cell/colour
// values when driven; a negedge monitor pops them at their due cycle.
module tb_grid_painter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hdata, vdata;
    logic [3:0] cursor_col, cursor_row;
    logic       cursor_vld;
    logic [7:0] video_red, video_green, video_blue;
    logic [3:0] cell_col, cell_row;
    logic       in_grid;

    grid_painter dut (
        .clk(clk), .rst_n(rst_n), .hdata(hdata), .vdata(vdata),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .cursor_vld(cursor_vld), .video_red(video_red),
        .video_green(video_green), .video_blue(video_blue),
        .cell_col(cell_col), .cell_row(cell_row), .in_grid(in_grid)
    );

    always #5 clk = ~clk;

    localparam logic [23:0] WHT = 24'hFFFFFF;
    localparam logic [23:0] BLK = 24'h000000;
    localparam logic [23:0] RED = 24'hFF0000;
`ifdef GRID_CHECKER_EN
    localparam logic [23:0] DIM = 24'hC0C0C0;
`else
    localparam logic [23:0] DIM = 24'hFFFFFF;
`endif

    typedef struct {
        int x; int y; logic [23:0] rgb;
        logic [3:0] col; logic [3:0] row; logic ing; string name;
    } cp_t;
    typedef struct {
        int due; logic [23:0] rgb;
        logic [3:0] col; logic [3:0] row; logic ing; string name;
    } sb_t;

    cp_t cp[$];
    sb_t cq[$];
    sb_t rq[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    int  red_seen = 0;
    bit  watch = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (cq.size() > 0 && cq[0].due <= cyc) begin
            sb_t e;
            e = cq.pop_front();
            total++;
            if (e.due != cyc || in_grid !== e.ing ||
                (e.ing && (cell_col !== e.col || cell_row !== e.row))) begin
                bad++;
                $display("FAIL %s cell: got ing=%b col=%0d row=%0d want ing=%b col=%0d row=%0d",
                         e.name, in_grid, cell_col, cell_row, e.ing, e.col, e.row);
            end
        end
        while (rq.size() > 0 && rq[0].due <= cyc) begin
            sb_t e;
            e = rq.pop_front();
            total++;
            if (e.due != cyc ||
                {video_red, video_green, video_blue} !== e.rgb) begin
                bad++;
                $display("FAIL %s rgb: got %h want %h", e.name,
                         {video_red, video_green, video_blue}, e.rgb);
            end
        end
        if (watch && video_red == 8'hFF && video_green == 8'h00 &&
            video_blue == 8'h00)
            red_seen++;
    end

    task automatic add_cp(input int x, input int y, input logic [23:0] rgb,
                          input int col, input int row, input logic ing,
                          input string name);
        cp_t c;
        c.x = x; c.y = y; c.rgb = rgb;
        c.col = 4'(col); c.row = 4'(row); c.ing = ing; c.name = name;
        cp.push_back(c);
    endtask

    task automatic drive(input int x, input int y);
        @(posedge clk);
        #1;
        hdata = 10'(x);
        vdata = 10'(y);
        foreach (cp[i]) begin
            if (cp[i].x == x && cp[i].y == y) begin
                sb_t e;
                e.rgb = cp[i].rgb; e.col = cp[i].col; e.row = cp[i].row;
                e.ing = cp[i].ing; e.name = cp[i].name;
                e.due = cyc + 1;
                cq.push_back(e);
                e.due = cyc + 2;
                rq.push_back(e);
            end
        end
    endtask

    // Lines without checkpoints are shortened to hdata=0 plus one off-grid pixel
    task automatic line(input int y, input int xmax);
        drive(0, y);
        if (xmax > 0) begin
            for (int x = 1; x <= xmax; x++) drive(x, y);
        end else begin
            drive(799, y);
        end
    endtask

    task automatic partial(input int y0, input int y1, input int chg_y,
                           input int ncol, input int nrow, input logic nvld);
        for (int y = y0; y <= y1; y++) begin
            int xm;
            if (y == chg_y) begin
                cursor_col = 4'(ncol);
                cursor_row = 4'(nrow);
                cursor_vld = nvld;
            end
            xm = 0;
            foreach (cp[i]) if (cp[i].y == y && cp[i].x > xm) xm = cp[i].x;
            line(y, xm);
        end
    endtask

    task automatic drain(input string name);
        repeat (4) drive(799, 524);
        total++;
        if (cq.size() != 0 || rq.size() != 0) begin
            bad++;
            $display("FAIL %s drain: got %0d/%0d pending want 0/0",
                     name, cq.size(), rq.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({video_red, video_green, video_blue} !== 24'h0) begin
            bad++;
            $display("FAIL reset_rgb: got %h want 000000",
                     {video_red, video_green, video_blue});
        end
        total++;
        if (cell_col !== 4'd0 || cell_row !== 4'd0 || in_grid !== 1'b0) begin
            bad++;
            $display("FAIL reset_cell: got col=%0d row=%0d ing=%b want 0 0 0",
                     cell_col, cell_row, in_grid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_frame();
        cp.delete();
        add_cp(40, 40, BLK, 0, 0, 1'b1, "org_line");
        add_cp(60, 60, WHT, 0, 0, 1'b1, "cell00");
        add_cp(100, 60, DIM, 1, 0, 1'b1, "cell10");
        add_cp(439, 439, WHT, 9, 9, 1'b1, "cell99");
        add_cp(440, 100, BLK, 10, 1, 1'b1, "close_h");
        add_cp(100, 440, BLK, 1, 10, 1'b1, "close_v");
        add_cp(441, 100, BLK, 0, 0, 1'b0, "past_h");
        add_cp(30, 30, BLK, 0, 0, 1'b0, "before_org");
        partial(0, 524, -1, 0, 0, 1'b0);
        drain("frame");
    endtask

    task automatic test_latency();
        cp.delete();
        partial(40, 59, -1, 0, 0, 1'b0);
        add_cp(40, 60, BLK, 0, 0, 1'b1, "lat_line");
        add_cp(41, 60, WHT, 0, 0, 1'b1, "lat_first");
        add_cp(60, 60, WHT, 0, 0, 1'b1, "lat_60");
        drive(0, 60);
        for (int x = 40; x <= 60; x++) drive(x, 60);
        drive(40, 60);
        drive(799, 60);
        drain("latency");
    endtask

    task automatic test_cursor();
        cursor_col = 4'd3; cursor_row = 4'd2; cursor_vld = 1'b1;
        cp.delete();
        add_cp(161, 140, RED, 3, 2, 1'b1, "cur_left");
        add_cp(198, 140, RED, 3, 2, 1'b1, "cur_right");
        add_cp(180, 122, RED, 3, 2, 1'b1, "cur_top");
        add_cp(180, 140, DIM, 3, 2, 1'b1, "cur_inside");
        add_cp(160, 140, RED, 3, 2, 1'b1, "cur_over_line");
        add_cp(241, 260, WHT, 5, 5, 1'b1, "cur_not_yet");
        partial(0, 524, 100, 5, 5, 1'b1);
        drain("cursor_a");
        cp.delete();
        add_cp(241, 260, RED, 5, 5, 1'b1, "cur_moved");
        add_cp(260, 260, WHT, 5, 5, 1'b1, "cur_moved_in");
        add_cp(161, 140, DIM, 3, 2, 1'b1, "cur_old_gone");
        partial(0, 524, -1, 0, 0, 1'b0);
        drain("cursor_b");
    endtask

    task automatic test_no_cursor();
        cursor_col = 4'd10; cursor_row = 4'd2; cursor_vld = 1'b1;
        cp.delete();
        add_cp(440, 140, BLK, 10, 2, 1'b1, "oor_close");
        add_cp(439, 140, DIM, 9, 2, 1'b1, "oor_cell92");
        add_cp(441, 140, BLK, 0, 0, 1'b0, "oor_past");
        add_cp(441, 80, BLK, 0, 0, 1'b0, "oor_r80");
        add_cp(441, 260, BLK, 0, 0, 1'b0, "oor_r260");
        red_seen = 0;
        watch = 1'b1;
        partial(0, 524, -1, 0, 0, 1'b0);
        drain("no_cursor");
        watch = 1'b0;
        total++;
        if (red_seen !== 0) begin
            bad++;
            $display("FAIL oor_red: got %0d red pixels want 0", red_seen);
        end
    endtask

    task automatic test_reset_midline();
        cursor_col = 4'd3; cursor_row = 4'd2; cursor_vld = 1'b1;
        cp.delete();
        partial(40, 59, -1, 0, 0, 1'b0);
        drive(0, 60);
        for (int x = 40; x <= 70; x++) drive(x, 60);
        #3;
        total++;
        if (video_red !== 8'hFF) begin
            bad++;
            $display("FAIL pre_reset: got %h want ff", video_red);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({video_red, video_green, video_blue} !== 24'h0 || in_grid !== 1'b0 ||
            cell_col !== 4'd0 || cell_row !== 4'd0) begin
            bad++;
            $display("FAIL midreset: got rgb=%h ing=%b col=%0d row=%0d want 0",
                     {video_red, video_green, video_blue}, in_grid, cell_col, cell_row);
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        add_cp(161, 140, DIM, 3, 2, 1'b1, "rst_cur_hidden");
        add_cp(60, 60, WHT, 0, 0, 1'b1, "rst_heal");
        partial(40, 140, -1, 0, 0, 1'b0);
        drain("reset_a");
        cp.delete();
        add_cp(161, 140, RED, 3, 2, 1'b1, "rst_cur_back");
        add_cp(60, 60, WHT, 0, 0, 1'b1, "rst_cell00");
        add_cp(100, 60, DIM, 1, 0, 1'b1, "rst_cell10");
        partial(0, 524, -1, 0, 0, 1'b0);
        drain("reset_b");
    endtask

    initial begin
        rst_n = 1'b0;
        hdata = 10'd799;
        vdata = 10'd524;
        cursor_col = 4'd0;
        cursor_row = 4'd0;
        cursor_vld = 1'b0;
        test_reset();
        test_frame();
        test_latency();
        test_cursor();
        test_no_cursor();
        test_reset_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
